dmem_responder: RTL and testbench

Data-memory responder for the single-cycle RV32I core: the far end of the MemRead/MemWr/MemtoReg control path. It accepts one load or store per request from the execute/memory stage, holds the core with a `stall` output for a fixed access latency, and returns sign- or zero-extended load data or commits byte-masked store data. It sits between the ALU address result and the write-back mux.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, load/store size encoding
// and the data-memory responder FSM type.
package riscv_pkg;

   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;

   // funct3 of loads/stores; encodings not listed behave as a word access
   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage with per-byte write enable and combinational read.
module dmem_array #(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: stalls the core LAT cycles per access,
// steers byte lanes and extends loads. DMEM_MISALIGN_TRAP_EN enables misalign trapping.
module dmem_responder
   import riscv_pkg::*;
#(
   parameter  int DEPTH  = 256,
   parameter  int LAT    = 2,
   localparam int ADDR_W = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_wr,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              misalign
);

   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   dmem_state_e       state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              accept, commit;
   logic [ADDR_W-1:0] addr_q, e_addr;
   logic [2:0]        f3_q, e_f3;
   logic [31:0]       wdata_q, e_wdata;
   logic              wr_q, e_wr;
   logic              req;

   logic        is_b, is_h, uns, mis;
   logic [31:0] rword, shifted, load_val, st_data;
   logic [15:0] half_v;
   logic [3:0]  be, we;

   assign req = mem_read | mem_wr;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (LAT == 1) begin
                  state_nxt = DONE;
                  commit    = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_W'(LAT - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = DONE;
               commit    = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign stall = !rst && ((state == IDLE && req) || state == WAIT);

   // With LAT==1 the commit edge is the accept edge, so the live inputs are used
   assign e_addr  = (state == IDLE) ? addr   : addr_q;
   assign e_f3    = (state == IDLE) ? funct3 : f3_q;
   assign e_wdata = (state == IDLE) ? wdata  : wdata_q;
   assign e_wr    = (state == IDLE) ? mem_wr : wr_q;

   always_comb begin
      is_b = 1'b0;
      is_h = 1'b0;
      case (mem_size_e'(e_f3))
         MEM_B, MEM_BU: is_b = 1'b1;
         MEM_H, MEM_HU: is_h = 1'b1;
         default:       ;
      endcase
   end
   assign uns = e_f3[2];

`ifdef DMEM_MISALIGN_TRAP_EN
   assign mis = (is_h && e_addr[0]) || (!is_b && !is_h && e_addr[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   always_comb begin
      shifted  = rword >> {e_addr[1:0], 3'b000};
      half_v   = e_addr[1] ? rword[31:16] : rword[15:0];
      load_val = rword;
      if (is_b)      load_val = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      else if (is_h) load_val = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      if (mis)       load_val = 32'h0;
   end

   always_comb begin
      be      = 4'b1111;
      st_data = e_wdata;
      if (is_b) begin
         be      = 4'b0001 << e_addr[1:0];
         st_data = {4{e_wdata[7:0]}};
      end else if (is_h) begin
         be      = e_addr[1] ? 4'b1100 : 4'b0011;
         st_data = {2{e_wdata[15:0]}};
      end
   end

   assign we = (commit && e_wr && !mis && !rst) ? be : 4'b0000;

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk   (clk),
      .we    (we),
      .idx   (e_addr[ADDR_W-1:2]),
      .wdata (st_data),
      .rdata (rword)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rdata    <= 32'h0;
         misalign <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            addr_q  <= addr;
            f3_q    <= funct3;
            wdata_q <= wdata;
            wr_q    <= mem_wr;
         end
         if (commit) begin
            misalign <= mis;
            if (!e_wr) rdata <= load_val;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LAT=2, LAT=3, LAT=1.
module tb_dmem_responder;

   localparam int S2 = 0;
   localparam int S3 = 1;
   localparam int S1 = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  funct3 = 3'b000;
   logic [9:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic        rd2 = 0, wr2 = 0, rd3 = 0, wr3 = 0, rd1 = 0, wr1 = 0;
   logic [31:0] rdata2, rdata3, rdata1;
   logic        stall2, stall3, stall1;
   logic        mis2, mis3, mis1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(256), .LAT(2)) u2 (
      .clk(clk), .rst(rst), .mem_read(rd2), .mem_wr(wr2), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata2), .stall(stall2), .misalign(mis2));
   dmem_responder #(.DEPTH(256), .LAT(3)) u3 (
      .clk(clk), .rst(rst), .mem_read(rd3), .mem_wr(wr3), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata3), .stall(stall3), .misalign(mis3));
   dmem_responder #(.DEPTH(256), .LAT(1)) u1 (
      .clk(clk), .rst(rst), .mem_read(rd1), .mem_wr(wr1), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata1), .stall(stall1), .misalign(mis1));

   function automatic logic cur_stall(input int s);
      case (s)
         S2:      return stall2;
         S3:      return stall3;
         default: return stall1;
      endcase
   endfunction

   function automatic logic [31:0] cur_rdata(input int s);
      case (s)
         S2:      return rdata2;
         S3:      return rdata3;
         default: return rdata1;
      endcase
   endfunction

   function automatic logic cur_mis(input int s);
      case (s)
         S2:      return mis2;
         S3:      return mis3;
         default: return mis1;
      endcase
   endfunction

   task automatic set_req(input int s, input logic rd, input logic wr);
      rd2 = (s == S2) ? rd : 1'b0;  wr2 = (s == S2) ? wr : 1'b0;
      rd3 = (s == S3) ? rd : 1'b0;  wr3 = (s == S3) ? wr : 1'b0;
      rd1 = (s == S1) ? rd : 1'b0;  wr1 = (s == S1) ? wr : 1'b0;
   endtask

   // Presents one request, counts stall cycles, samples outputs in the first non-stall cycle.
   task automatic req(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [9:0] a, input logic [31:0] wd,
                      output int ns, output logic [31:0] rv, output logic mv);
      int guard;
      logic done;
      @(negedge clk);
      funct3 = f3; addr = a; wdata = wd;
      set_req(s, rd, wr);
      ns = 0; guard = 0; done = 1'b0;
      while (!done && guard < 20) begin
         #1;
         if (cur_stall(s) === 1'b1) begin
            ns++;
            guard++;
            @(negedge clk);
         end else begin
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL req_timeout: stall still high after %0d cycles, required low", guard);
      end
      rv = cur_rdata(s);
      mv = cur_mis(s);
      @(posedge clk);
      #1;
      set_req(s, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      set_req(S2, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (stall2 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall2); end
      checks++;
      if ({rdata2, rdata3, rdata1} !== 96'h0) begin
         errors++; $display("FAIL reset_rdata: got %h %h %h want 0", rdata2, rdata3, rdata1);
      end
      checks++;
      if ({mis2, mis3, mis1} !== 3'b000) begin
         errors++; $display("FAIL reset_misalign: got %b want 000", {mis2, mis3, mis1});
      end
      set_req(S2, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_store_load;
      int ns; logic [31:0] rv; logic mv;
      req(S2, 0, 1, 3'b010, 10'h010, 32'hDEADBEEF, ns, rv, mv);
      checks++;
      if (ns !== 2) begin errors++; $display("FAIL sw_stall_cycles: got %0d want 2", ns); end
      req(S2, 1, 0, 3'b010, 10'h010, 32'h0, ns, rv, mv);
      checks++;
      if (ns !== 2) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 2", ns); end
      checks++;
      if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", rv); end
   endtask

   task automatic test_extend;
      int ns; logic [31:0] rv; logic mv;
      logic [2:0]  f3_t [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b011};
      logic [9:0]  a_t  [6] = '{10'h013, 10'h013, 10'h012, 10'h010, 10'h011, 10'h010};
      logic [31:0] e_t  [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                                32'h0000BEEF, 32'hFFFFFFBE, 32'hDEADBEEF};
      for (int i = 0; i < 6; i++) begin
         req(S2, 1, 0, f3_t[i], a_t[i], 32'h0, ns, rv, mv);
         checks++;
         if (rv !== e_t[i]) begin
            errors++; $display("FAIL load_ext[%0d]: got %h want %h", i, rv, e_t[i]);
         end
      end
   endtask

   task automatic test_partial_store;
      int ns; logic [31:0] rv; logic mv;
      req(S2, 0, 1, 3'b001, 10'h012, 32'hFFFF1234, ns, rv, mv);
      req(S2, 1, 0, 3'b010, 10'h010, 32'h0, ns, rv, mv);
      checks++;
      if (rv !== 32'h1234BEEF) begin errors++; $display("FAIL sh_merge: got %h want 1234beef", rv); end
      req(S2, 0, 1, 3'b000, 10'h010, 32'hABCDEF77, ns, rv, mv);
      req(S2, 1, 0, 3'b010, 10'h010, 32'h0, ns, rv, mv);
      checks++;
      if (rv !== 32'h1234BE77) begin errors++; $display("FAIL sb_merge: got %h want 1234be77", rv); end
   endtask

   task automatic test_misalign;
      int ns; logic [31:0] rv; logic mv;
`ifdef DMEM_MISALIGN_TRAP_EN
      req(S2, 1, 0, 3'b010, 10'h011, 32'h0, ns, rv, mv);
      checks++;
      if (mv !== 1'b1 || rv !== 32'h0) begin
         errors++; $display("FAIL lw_misalign: got mis=%b rdata=%h want mis=1 rdata=0", mv, rv);
      end
      checks++;
      if (ns !== 2) begin errors++; $display("FAIL misalign_latency: got %0d want 2", ns); end
      req(S2, 0, 1, 3'b010, 10'h011, 32'hCAFEF00D, ns, rv, mv);
      req(S2, 1, 0, 3'b010, 10'h010, 32'h0, ns, rv, mv);
      checks++;
      if (mv !== 1'b0 || rv !== 32'h1234BE77) begin
         errors++; $display("FAIL sw_misalign_suppressed: got mis=%b rdata=%h want mis=0 rdata=1234be77", mv, rv);
      end
      req(S2, 1, 0, 3'b001, 10'h013, 32'h0, ns, rv, mv);
      checks++;
      if (mv !== 1'b1) begin errors++; $display("FAIL lh_misalign: got mis=%b want 1", mv); end
`else
      req(S2, 1, 0, 3'b010, 10'h011, 32'h0, ns, rv, mv);
      checks++;
      if (mv !== 1'b0 || rv !== 32'h1234BE77) begin
         errors++; $display("FAIL lw_unaligned: got mis=%b rdata=%h want mis=0 rdata=1234be77", mv, rv);
      end
      req(S2, 1, 0, 3'b001, 10'h013, 32'h0, ns, rv, mv);
      checks++;
      if (mv !== 1'b0 || rv !== 32'h00001234) begin
         errors++; $display("FAIL lh_unaligned: got mis=%b rdata=%h want mis=0 rdata=00001234", mv, rv);
      end
`endif
   endtask

   task automatic test_back_to_back;
      logic [5:0] pat;
      pat = '0;
      @(negedge clk);
      funct3 = 3'b010; addr = 10'h010; wdata = 32'h0;
      set_req(S2, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         #1;
         pat = {pat[4:0], stall2};
         @(negedge clk);
      end
      set_req(S2, 1'b0, 1'b0);
      checks++;
      if (pat !== 6'b110110) begin errors++; $display("FAIL back_to_back_stall: got %b want 110110", pat); end
      checks++;
      if (rdata2 !== 32'h1234BE77) begin errors++; $display("FAIL back_to_back_data: got %h want 1234be77", rdata2); end
   endtask

   task automatic test_reset_mid;
      int ns; logic [31:0] rv; logic mv;
      req(S3, 0, 1, 3'b010, 10'h020, 32'h11111111, ns, rv, mv);
      checks++;
      if (ns !== 3) begin errors++; $display("FAIL lat3_stall_cycles: got %0d want 3", ns); end
      @(negedge clk);
      funct3 = 3'b010; addr = 10'h020; wdata = 32'hAAAAAAAA;
      set_req(S3, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (stall3 !== 1'b0) begin errors++; $display("FAIL stall_in_reset: got %b want 0", stall3); end
      @(negedge clk);
      set_req(S3, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      checks++;
      if (stall3 !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b want 0", stall3); end
      req(S3, 1, 0, 3'b010, 10'h020, 32'h0, ns, rv, mv);
      checks++;
      if (rv !== 32'h11111111) begin errors++; $display("FAIL interrupted_store: got %h want 11111111", rv); end
   endtask

   task automatic test_read_write;
      int ns; logic [31:0] rv; logic mv;
      req(S1, 0, 1, 3'b010, 10'h030, 32'h00000099, ns, rv, mv);
      checks++;
      if (ns !== 1) begin errors++; $display("FAIL lat1_stall_cycles: got %0d want 1", ns); end
      req(S1, 1, 0, 3'b010, 10'h030, 32'h0, ns, rv, mv);
      checks++;
      if (rv !== 32'h00000099) begin errors++; $display("FAIL lat1_load: got %h want 00000099", rv); end
      req(S1, 1, 1, 3'b010, 10'h030, 32'h00000005, ns, rv, mv);
      checks++;
      if (ns !== 1 || rv !== 32'h00000099) begin
         errors++; $display("FAIL rw_rdata_hold: got stalls=%0d rdata=%h want 1 00000099", ns, rv);
      end
      req(S1, 1, 0, 3'b010, 10'h030, 32'h0, ns, rv, mv);
      checks++;
      if (rv !== 32'h00000005) begin errors++; $display("FAIL rw_is_write: got %h want 00000005", rv); end
   endtask

   initial begin
      test_reset;
      test_store_load;
      test_extend;
      test_partial_store;
      test_misalign;
      test_back_to_back;
      test_reset_mid;
      test_read_write;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
